// File: rtl/fp_pkg.sv
// Shared types, constants and operand-class helpers for the FP issue stage.
package fp_pkg;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HOLD} state_t;
    typedef enum logic {OP_ADD = 1'b0, OP_MUL = 1'b1} op_t;
    typedef enum logic [1:0] {ZERO, NORM, INF, NAN} cls_t;

    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    localparam int unsigned FLAG_NAN     = 0;
    localparam int unsigned FLAG_INF     = 1;
    localparam int unsigned FLAG_ZERO    = 2;
    localparam int unsigned FLAG_TIMEOUT = 3;

    typedef struct packed {
        op_t         op;
        logic [31:0] a;
        logic [31:0] b;
    } entry_t;

    // Exponent 0 is always ZERO: denormals are flushed.
    function automatic cls_t classify(input logic [31:0] x);
        if (x[30:23] == 8'h00) return ZERO;
        if (x[30:23] != 8'hFF) return NORM;
        return (x[22:0] == '0) ? INF : NAN;
    endfunction

    function automatic logic [3:0] result_flags(input logic [31:0] r);
        logic [3:0] f;
        f = '0;
        unique case (classify(r))
            ZERO:    f[FLAG_ZERO] = 1'b1;
            INF:     f[FLAG_INF]  = 1'b1;
            NAN:     f[FLAG_NAN]  = 1'b1;
            default: f = '0;
        endcase
        return f;
    endfunction

    function automatic logic [3:0] timeout_flags();
        logic [3:0] f;
        f = '0;
        f[FLAG_TIMEOUT] = 1'b1;
        f[FLAG_NAN]     = 1'b1;
        return f;
    endfunction

    function automatic logic is_special(input logic [31:0] a, input logic [31:0] b);
        return (classify(a) != NORM) || (classify(b) != NORM);
    endfunction

    // Only meaningful when at least one operand is not NORM; rule order matters.
    function automatic logic [31:0] special_result(input op_t op, input logic [31:0] a,
                                                   input logic [31:0] b);
        cls_t ca;
        cls_t cb;
        ca = classify(a);
        cb = classify(b);
        if (ca == NAN || cb == NAN) return QNAN;
        if (op == OP_ADD) begin
            if (ca == INF && cb == INF) return (a[31] != b[31]) ? QNAN : a;
            if (ca == INF) return a;
            if (cb == INF) return b;
            if (ca == ZERO && cb == ZERO) return {a[31] & b[31], 31'd0};
            if (ca == ZERO) return b;
            return a;
        end
        if ((ca == INF && cb == ZERO) || (ca == ZERO && cb == INF)) return QNAN;
        if (ca == INF || cb == INF) return {a[31] ^ b[31], 8'hFF, 23'd0};
        return {a[31] ^ b[31], 31'd0};
    endfunction

endpackage

// File: rtl/fp_issue_stage_if.sv
// Request, FP-core and result channels of the FP issue stage.
interface fp_issue_stage_if;
    logic        in_valid;
    logic        in_ready;
    logic        in_op;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic        core_start;
    logic        core_add_or_mul;
    logic [31:0] core_a;
    logic [31:0] core_b;
    logic        core_done;
    logic [31:0] core_result;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic [3:0]  out_flags;
    logic        busy;

    modport master (
        output in_valid, in_op, in_a, in_b, core_done, core_result, out_ready,
        input  in_ready, core_start, core_add_or_mul, core_a, core_b,
               out_valid, out_result, out_flags, busy
    );

    modport slave (
        input  in_valid, in_op, in_a, in_b, core_done, core_result, out_ready,
        output in_ready, core_start, core_add_or_mul, core_a, core_b,
               out_valid, out_result, out_flags, busy
    );
endinterface

// File: rtl/fp_issue_fifo.sv
// Operation buffer: power-of-two FIFO with first-word-fall-through read.
module fp_issue_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 65
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wptr;
    logic [AW:0]      rptr;

    assign empty = (wptr == rptr);
    assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign rdata = mem[rptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (push && !full) mem[wptr[AW-1:0]] <= wdata;
    end

    // A push is refused whenever full, even if a pop frees a slot this cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push && !full) wptr <= wptr + 1'b1;
            if (pop && !empty) rptr <= rptr + 1'b1;
        end
    end
endmodule

// File: rtl/fp_issue_stage.sv
// Buffers FP add/mul requests and issues them one at a time to an external core.
// Define FP_SPECIAL_BYPASS_EN to resolve zero/inf/NaN operands locally without the core.
module fp_issue_stage
    import fp_pkg::*;
#(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned TIMEOUT = 64
) (
    input logic               clk,
    input logic               rst,
    fp_issue_stage_if.slave   bus
);
    localparam int unsigned CW = $clog2(TIMEOUT + 1);

    state_t      state;
    entry_t      req;
    entry_t      head;
    logic        full;
    logic        empty;
    logic        push;
    logic        pop;
    logic        head_special;
    logic [CW-1:0] wait_cnt;

    logic        core_start;
    logic        core_add_or_mul;
    logic [31:0] core_a;
    logic [31:0] core_b;
    logic        out_valid;
    logic [31:0] out_result;
    logic [3:0]  out_flags;

    assign req  = '{op: op_t'(bus.in_op), a: bus.in_a, b: bus.in_b};
    assign push = bus.in_valid && !full;
    assign pop  = (state == HOLD) && bus.out_ready;

    fp_issue_fifo #(.DEPTH(DEPTH), .WIDTH($bits(entry_t))) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .wdata (req),
        .rdata (head),
        .full  (full),
        .empty (empty)
    );

`ifdef FP_SPECIAL_BYPASS_EN
    assign head_special = is_special(head.a, head.b);
`else
    assign head_special = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            core_start      <= 1'b0;
            core_add_or_mul <= 1'b0;
            core_a          <= '0;
            core_b          <= '0;
            out_valid       <= 1'b0;
            out_result      <= '0;
            out_flags       <= '0;
            wait_cnt        <= '0;
        end else begin
            unique case (state)
                IDLE: if (!empty) begin
                    if (head_special) begin
                        out_result <= special_result(head.op, head.a, head.b);
                        out_flags  <= result_flags(special_result(head.op, head.a, head.b));
                        out_valid  <= 1'b1;
                        state      <= HOLD;
                    end else begin
                        core_start      <= 1'b1;
                        core_add_or_mul <= head.op;
                        core_a          <= head.a;
                        core_b          <= head.b;
                        state           <= ISSUE;
                    end
                end
                ISSUE: begin
                    core_start <= 1'b0;
                    wait_cnt   <= '0;
                    state      <= WAIT;
                end
                WAIT: begin
                    // A done arriving on the final WAIT cycle still wins over the timeout.
                    if (bus.core_done) begin
                        out_result <= bus.core_result;
                        out_flags  <= result_flags(bus.core_result);
                        out_valid  <= 1'b1;
                        wait_cnt   <= '0;
                        state      <= HOLD;
                    end else if (wait_cnt == CW'(TIMEOUT - 1)) begin
                        out_result <= QNAN;
                        out_flags  <= timeout_flags();
                        out_valid  <= 1'b1;
                        wait_cnt   <= '0;
                        state      <= HOLD;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                HOLD: if (bus.out_ready) begin
                    out_valid <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready        = !full;
    assign bus.core_start      = core_start;
    assign bus.core_add_or_mul = core_add_or_mul;
    assign bus.core_a          = core_a;
    assign bus.core_b          = core_b;
    assign bus.out_valid       = out_valid;
    assign bus.out_result      = out_result;
    assign bus.out_flags       = out_flags;
    assign bus.busy            = (state != IDLE) || !empty;
endmodule

// File: doc/fp_issue_stage.md
FP_ISSUE_STAGE -- requirements
Module: fp_issue_stage

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, meaning operation-buffer entries (power of two, >=2).
REQ-002 The block SHALL have parameter TIMEOUT, default 64, meaning the number of WAIT cycles before the core is declared hung.
REQ-003 The block SHALL have port clk, input, 1, the clock.
REQ-004 The block SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 The block SHALL have ports in_valid input 1, in_ready output 1, in_op input 1 (0 add, 1 mul), in_a input 32, in_b input 32, forming the operation request channel.
REQ-006 The block SHALL have ports core_start output 1, core_add_or_mul output 1, core_a output 32, core_b output 32, core_done input 1, core_result input 32, forming the FP core channel.
REQ-007 The block SHALL have ports out_valid output 1, out_ready input 1, out_result output 32, out_flags output 4 ({timeout, zero, inf, nan}), busy output 1.

Function
REQ-008 A request SHALL be accepted on a clk edge with in_valid && in_ready; in_ready SHALL equal !full, and a full buffer SHALL NOT accept even when a pop occurs in the same cycle.
REQ-009 The buffer SHALL be FIFO-ordered; results SHALL leave in acceptance order.
REQ-010 The FSM SHALL have states IDLE, ISSUE, WAIT, HOLD.
REQ-011 IDLE: if the buffer is non-empty, go to HOLD when the head is a special case (REQ-015), else to ISSUE; if empty, stay.
REQ-012 ISSUE: core_start SHALL be 1 for exactly this one cycle, then WAIT; core_a, core_b and core_add_or_mul SHALL equal the head entry from ISSUE through the end of WAIT.
REQ-013 WAIT: core_done=1 SHALL capture core_result into out_result and go to HOLD; after TIMEOUT WAIT cycles without core_done, out_result SHALL be 0x7FC00000 with flags 4'b1001 and the FSM SHALL go to HOLD.
REQ-014 HOLD: out_valid=1 and out_result/out_flags stable; on out_ready the head SHALL be popped and the FSM SHALL return to IDLE; core_done seen outside WAIT SHALL be ignored.
REQ-015 Special cases: exponent 0 SHALL be treated as zero (denormals flushed); any NaN gives 0x7FC00000; add inf+(-inf) and mul inf*0 give 0x7FC00000; add inf+x gives that inf; mul with inf gives inf signed a^b; mul with zero gives zero signed a^b; add zero+x gives x; add zero+zero gives -0 only if both are negative, else +0.
REQ-016 out_flags nan/inf/zero SHALL reflect the result encoding for both core and special results; timeout SHALL be set only by REQ-013.
REQ-017 busy SHALL be 1 whenever the state is not IDLE or the buffer is non-empty.
REQ-018 A special request accepted on edge t with an empty buffer and IDLE state SHALL have out_valid at cycle t+2; a normal request SHALL have core_start at cycle t+2.

Reset
REQ-019 rst SHALL empty the buffer and force IDLE, with in_ready=1 and core_start, out_valid, busy, out_flags, out_result, and the timeout counter all 0; rst mid-WAIT SHALL abandon the operation without an output.

Configuration
REQ-020 With FP_SPECIAL_BYPASS_EN defined, REQ-015 bypass SHALL apply; without it, every request SHALL go through ISSUE/WAIT and flags SHALL still be derived from the result.

Structure
REQ-021 Package fp_pkg SHALL hold the state enum, the op encoding, the QNAN constant 0x7FC00000, the flag bit indices, and the operand-class typedef (ZERO, NORM, INF, NAN).
REQ-022 The buffer SHALL be sub-module fp_issue_fifo (DEPTH, 65-bit entry, push/pop/full/empty).

Verification
REQ-023 Add 0x3F800000+0x40000000 with the core returning 0x40400000 after 10 cycles -> one core_start pulse, then out_result=0x40400000, out_flags=0.
REQ-024 Mul 0x7F800000*0x00000000 (bypass on) -> no core_start, out_result=0x7FC00000, out_flags=4'b0001 at t+2.
REQ-025 Push 5 requests with out_ready=0 and DEPTH=4 -> in_ready=0 after the 4th accept; results drain in order once out_ready=1.
REQ-026 No core_done for 64 cycles -> out_result=0x7FC00000, out_flags=4'b1001; a later core_done is ignored.
REQ-027 Assert rst during WAIT -> the next cycle has busy=0 and out_valid=0; the following request is processed normally.
